// File: rtl/fetch_pc_unit.sv
// Fetch-stage PC register with next-PC selection for branches, jumps,
// exception entry and eret, plus the branch-likely delay-slot annul.
module fetch_pc_unit #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_3000,
  parameter logic [ADDR_W-1:0] EXC_PC   = 32'h0000_4180
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall_i,
  input  logic [3:0]        npc_op,
  input  logic [ADDR_W-1:0] d_pc,
  input  logic [25:0]       imm26,
  input  logic [ADDR_W-1:0] rs_val,
  input  logic [ADDR_W-1:0] rt_val,
  input  logic              exc_req,
  input  logic              eret_req,
  input  logic [ADDR_W-1:0] epc,
  output logic [ADDR_W-1:0] pc_o,
  output logic              flush_d_o,
  output logic              taken_o,
  output logic              misalign_o
);

  localparam logic [3:0] OP_BEQ  = 4'd1;
  localparam logic [3:0] OP_BNE  = 4'd2;
  localparam logic [3:0] OP_BLEZ = 4'd3;
  localparam logic [3:0] OP_BGTZ = 4'd4;
  localparam logic [3:0] OP_BLTZ = 4'd5;
  localparam logic [3:0] OP_BGEZ = 4'd6;
  localparam logic [3:0] OP_J    = 4'd7;
  localparam logic [3:0] OP_JR   = 4'd8;
  localparam logic [3:0] OP_BEQL = 4'd9;
  localparam logic [3:0] OP_BNEL = 4'd10;

  localparam logic [ADDR_W-1:0] PC_STEP   = ADDR_W'(32'd4);
  localparam logic              RESET_MIS = |RESET_PC[1:0];

  logic [ADDR_W-1:0] r_pc;
  logic              r_misalign;
  logic [ADDR_W-1:0] w_boff;
  logic [ADDR_W-1:0] w_btgt;
  logic [ADDR_W-1:0] w_jtgt;
  logic [ADDR_W-1:0] w_tgt;
  logic [ADDR_W-1:0] w_npc;
  logic              w_rs_neg;
  logic              w_rs_zero;
  logic              w_eq;
  logic              w_cond;
  logic              w_likely;
  logic              w_taken;
  logic              w_flush;

  // Branch condition and target for the instruction currently in D.
  always_comb begin
    w_boff    = {{(ADDR_W-18){imm26[15]}}, imm26[15:0], 2'b00};
    w_btgt    = d_pc + PC_STEP + w_boff;
    w_jtgt    = {d_pc[ADDR_W-1:28], imm26, 2'b00};
    w_rs_neg  = rs_val[ADDR_W-1];
    w_rs_zero = (rs_val == {ADDR_W{1'b0}});
    w_eq      = (rs_val == rt_val);
    w_cond    = 1'b0;
    w_likely  = 1'b0;
    w_tgt     = w_btgt;
    case (npc_op)
      OP_BEQ:  w_cond = w_eq;
      OP_BNE:  w_cond = ~w_eq;
      OP_BLEZ: w_cond = w_rs_neg | w_rs_zero;
      OP_BGTZ: w_cond = ~w_rs_neg & ~w_rs_zero;
      OP_BLTZ: w_cond = w_rs_neg;
      OP_BGEZ: w_cond = ~w_rs_neg;
      OP_J: begin
        w_cond = 1'b1;
        w_tgt  = w_jtgt;
      end
      OP_JR: begin
        w_cond = 1'b1;
        w_tgt  = rs_val;
      end
      OP_BEQL: begin
        w_cond   = w_eq;
        w_likely = 1'b1;
      end
      OP_BNEL: begin
        w_cond   = ~w_eq;
        w_likely = 1'b1;
      end
      default: w_cond = 1'b0;
    endcase
  end

  // Redirect priority: exception, eret, stall hold, taken transfer, sequential.
  always_comb begin
    w_taken = ~reset & w_cond & ~stall_i & ~exc_req & ~eret_req;
    w_flush = ~reset & (exc_req | eret_req | (w_likely & ~w_cond & ~stall_i));
    if (exc_req) begin
      w_npc = EXC_PC;
    end else if (eret_req) begin
      w_npc = epc;
    end else if (stall_i) begin
      w_npc = r_pc;
    end else if (w_taken) begin
      w_npc = w_tgt;
    end else begin
      w_npc = r_pc + PC_STEP;
    end
  end

  // PC register; misalign is registered alongside so it always tracks pc_o.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc       <= RESET_PC;
      r_misalign <= RESET_MIS;
    end else begin
      r_pc       <= w_npc;
      r_misalign <= |w_npc[1:0];
    end
  end

  assign pc_o       = r_pc;
  assign misalign_o = r_misalign;
  assign taken_o    = w_taken;
  assign flush_d_o  = w_flush;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit: an arithmetic reference model checked
// every negative edge, plus hand-computed literal expectations.
module tb_fetch_pc_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall_i;
  logic [3:0]  npc_op;
  logic [31:0] d_pc;
  logic [25:0] imm26;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        exc_req;
  logic        eret_req;
  logic [31:0] epc;
  logic [31:0] pc_o;
  logic        flush_d_o;
  logic        taken_o;
  logic        misalign_o;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] m_pc;

  fetch_pc_unit dut (
    .clk(clk), .reset(reset), .stall_i(stall_i), .npc_op(npc_op),
    .d_pc(d_pc), .imm26(imm26), .rs_val(rs_val), .rt_val(rt_val),
    .exc_req(exc_req), .eret_req(eret_req), .epc(epc),
    .pc_o(pc_o), .flush_d_o(flush_d_o), .taken_o(taken_o),
    .misalign_o(misalign_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: what the rules say the outputs and next PC must be.
  function automatic void model(input logic [31:0] cur, output bit tk,
                                output bit fl, output logic [31:0] nxt);
    longint srs = longint'($signed(rs_val));
    longint off = longint'($signed(imm26[15:0])) * 4;
    longint bt  = (longint'(d_pc) + 4 + off) % 64'h1_0000_0000;
    longint tgt = bt;
    bit cond = 0;
    bit likely = 0;
    case (npc_op)
      4'd1: cond = (rs_val == rt_val);
      4'd2: cond = (rs_val != rt_val);
      4'd3: cond = (srs <= 0);
      4'd4: cond = (srs > 0);
      4'd5: cond = (srs < 0);
      4'd6: cond = (srs >= 0);
      4'd7: begin
        cond = 1;
        tgt = (longint'(d_pc) / 64'h1000_0000) * 64'h1000_0000 + longint'(imm26) * 4;
      end
      4'd8: begin cond = 1; tgt = longint'(rs_val); end
      4'd9: begin cond = (rs_val == rt_val); likely = 1; end
      4'd10: begin cond = (rs_val != rt_val); likely = 1; end
      default: cond = 0;
    endcase
    tk = cond && !stall_i && !exc_req && !eret_req;
    fl = exc_req || eret_req || (likely && !cond && !stall_i);
    if (exc_req) nxt = 32'h0000_4180;
    else if (eret_req) nxt = epc;
    else if (stall_i) nxt = cur;
    else if (tk) nxt = tgt[31:0];
    else nxt = cur + 32'd4;
  endfunction

  // Model PC state.
  always @(posedge clk or posedge reset) begin
    bit tk, fl;
    logic [31:0] nxt;
    if (reset) m_pc <= 32'h0000_3000;
    else begin
      model(m_pc, tk, fl, nxt);
      m_pc <= nxt;
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    bit tk, fl;
    logic [31:0] nxt;
    if (reset) begin
      chk("rst_pc", pc_o, 32'h0000_3000);
      chk("rst_taken", {31'd0, taken_o}, 32'd0);
      chk("rst_flush", {31'd0, flush_d_o}, 32'd0);
    end else begin
      model(m_pc, tk, fl, nxt);
      chk("m_pc", pc_o, m_pc);
      chk("m_taken", {31'd0, taken_o}, {31'd0, tk});
      chk("m_flush", {31'd0, flush_d_o}, {31'd0, fl});
      chk("m_misalign", {31'd0, misalign_o}, {31'd0, |m_pc[1:0]});
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] op, input logic [31:0] dpc, input logic [15:0] im,
                       input logic [31:0] rs, input logic [31:0] rt);
    npc_op = op; d_pc = dpc; imm26 = {10'd0, im}; rs_val = rs; rt_val = rt;
  endtask

  initial begin
    reset = 1'b1; stall_i = 1'b0; exc_req = 1'b0; eret_req = 1'b0; epc = 32'd0;
    drive(4'd0, 32'd0, 16'd0, 32'd0, 32'd0);
    cyc(); cyc();
    reset = 1'b0;
    repeat (4) cyc();
    chk("pre_rst_pc", pc_o, 32'h0000_3010);
    @(posedge clk); #3;
    reset = 1'b1;
    #1;
    chk("async_rst", pc_o, 32'h0000_3000);
    cyc();
    reset = 1'b0;
    cyc(); chk("seq1", pc_o, 32'h0000_3004);
    cyc(); chk("seq2", pc_o, 32'h0000_3008);
    cyc(); chk("seq3", pc_o, 32'h0000_300C);

    drive(4'd1, 32'h3008, 16'hFFFE, 32'd5, 32'd5); #1;
    chk("beq_taken", {31'd0, taken_o}, 32'd1);
    chk("beq_noflush", {31'd0, flush_d_o}, 32'd0);
    cyc(); chk("beq_pc", pc_o, 32'h0000_3004);
    drive(4'd1, 32'h3008, 16'hFFFE, 32'd5, 32'd6);
    cyc(); chk("beq_nt_pc", pc_o, 32'h0000_3008);

    drive(4'd5, 32'h3008, 16'h0004, 32'h8000_0000, 32'd0); #1;
    chk("bltz_taken", {31'd0, taken_o}, 32'd1);
    cyc(); chk("bltz_pc", pc_o, 32'h0000_301C);
    drive(4'd4, 32'h3008, 16'h0004, 32'd0, 32'd0); #1;
    chk("bgtz_nt", {31'd0, taken_o}, 32'd0);
    cyc(); chk("bgtz_pc", pc_o, 32'h0000_3020);
    drive(4'd6, 32'h3008, 16'h0004, 32'd0, 32'd0);
    cyc(); chk("bgez_pc", pc_o, 32'h0000_301C);
    drive(4'd3, 32'h3018, 16'h0010, 32'hFFFF_FFFF, 32'd0);
    cyc(); chk("blez_pc", pc_o, 32'h0000_305C);
    drive(4'd2, 32'h3058, 16'hFFF0, 32'd1, 32'd1);
    cyc(); chk("bne_nt_pc", pc_o, 32'h0000_3060);

    drive(4'd9, 32'h305C, 16'h0008, 32'd1, 32'd2); #1;
    chk("beql_flush", {31'd0, flush_d_o}, 32'd1);
    cyc(); chk("beql_pc", pc_o, 32'h0000_3064);
    stall_i = 1'b1; #1;
    chk("beql_stall_flush", {31'd0, flush_d_o}, 32'd0);
    cyc(); chk("beql_stall_pc", pc_o, 32'h0000_3064);
    drive(4'd10, 32'h3060, 16'h0004, 32'd1, 32'd2); stall_i = 1'b0;
    cyc(); chk("bnel_pc", pc_o, 32'h0000_3074);

    drive(4'd7, 32'hA000_0000, 16'hFFFF, 32'd0, 32'd0); imm26 = 26'h3FF_FFFF;
    stall_i = 1'b1; #1;
    chk("stall_j_taken", {31'd0, taken_o}, 32'd0);
    cyc(); chk("stall_j_pc", pc_o, 32'h0000_3074);
    exc_req = 1'b1; #1;
    chk("exc_flush", {31'd0, flush_d_o}, 32'd1);
    cyc(); chk("exc_pc", pc_o, 32'h0000_4180);
    eret_req = 1'b1; epc = 32'h3020;
    cyc(); chk("exc_eret_pc", pc_o, 32'h0000_4180);
    exc_req = 1'b0; stall_i = 1'b0;
    cyc(); chk("eret_pc", pc_o, 32'h0000_3020);
    eret_req = 1'b0;
    cyc(); chk("j_pc", pc_o, 32'hAFFF_FFFC);
    drive(4'd12, 32'h0, 16'h0004, 32'd0, 32'd0);
    cyc(); chk("op12_seq", pc_o, 32'hB000_0000);

    drive(4'd8, 32'h0, 16'h0, 32'h0000_3002, 32'd0);
    cyc(); chk("jr_pc", pc_o, 32'h0000_3002);
    chk("jr_misalign", {31'd0, misalign_o}, 32'd1);
    drive(4'd8, 32'h0, 16'h0, 32'hFFFF_FFFC, 32'd0);
    cyc(); chk("jr_top", pc_o, 32'hFFFF_FFFC);
    drive(4'd0, 32'h0, 16'h0, 32'd0, 32'd0);
    cyc(); chk("wrap_pc", pc_o, 32'h0000_0000);
    chk("wrap_misalign", {31'd0, misalign_o}, 32'd0);
    cyc(); cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
